// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// byte-lane constants and the wait-counter width function.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

    // A zero-wait build still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        if (wait_cycles == 0) begin
            return 1;
        end else begin
            return $clog2(wait_cycles + 1);
        end
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_W storage with a byte-enabled synchronous write and a
// synchronous read-before-write output register; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 10
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [lanes(DATA_W)-1:0]  be,
    output logic [DATA_W-1:0]         rdata
);

    localparam int unsigned LANES = lanes(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Per-lane write; each lane only changes when its enable is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && be[i]) begin
                mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered read of the addressed word.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states and a held response.
// Optional macro DMEM_ERR_CHECK_EN flags addresses >= DEPTH with rsp_err instead of wrapping.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [lanes(DATA_W)-1:0]  req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err
);

    localparam int unsigned LANES    = lanes(DATA_W);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The array read needs one edge before commit, so commit never lands on the accept edge.
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = cnt_width(WAIT_EFF);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    be_q, be_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                err_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_addr_s;
    logic [DATA_W-1:0]   mem_rdata_s;
    logic                unused_addr_s;

`ifdef DMEM_ERR_CHECK_EN
    assign err_s = (32'(addr_q) >= 32'(DEPTH));
`else
    assign err_s = 1'b0;
`endif
    assign unused_addr_s = ^addr_q;

    // While idle the array reads the incoming address so data is ready by commit.
    assign mem_addr_s = (state_q == ST_IDLE) ? req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    // Next-state, request latch and response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_W'(WAIT_EFF);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mem_we_s    = rst_n & we_q & ~err_s;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (we_q || err_s) ? {DATA_W{1'b0}} : mem_rdata_s;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            be_q        <= {LANES{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (mem_rdata_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=512, WAIT_CYCLES=2);
// expectations for the out-of-range store follow DMEM_ERR_CHECK_EN.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (10),
        .DATA_W      (32),
        .DEPTH       (512),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after its accept edge with inputs scrambled.
    task automatic send_req(input logic we, input logic [9:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 10'h3FF;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] data,
                        output logic err, output int lat);
        send_req(we, addr, wd, be);
        wait_rsp(lat);
        data = rsp_rdata;
        err  = rsp_err;
        take_rsp();
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0;
        req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        // Full store then load.
        xact(1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF, d, e, lat);
        check("st_lat", lat, 32'd2);
        check("st_rdata", d, 32'd0);
        check("st_err", {31'd0, e}, 32'd0);
        xact(1'b0, 10'h005, 32'd0, 4'h0, d, e, lat);
        check("ld_lat", lat, 32'd2);
        check("ld_rdata", d, 32'hDEAD_BEEF);

        // Partial store on lanes 0 and 2.
        xact(1'b1, 10'h005, 32'h1122_3344, 4'b0101, d, e, lat);
        xact(1'b0, 10'h005, 32'd0, 4'h0, d, e, lat);
        check("part_rdata", d, 32'hDE22_BE44);

        // Store with no byte enables leaves the word alone.
        xact(1'b1, 10'h005, 32'h0000_0000, 4'h0, d, e, lat);
        xact(1'b0, 10'h005, 32'd0, 4'h0, d, e, lat);
        check("be0_rdata", d, 32'hDE22_BE44);

        // Backpressure with a competing request held pending.
        send_req(1'b0, 10'h005, 32'd0, 4'h0);
        wait_rsp(lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h007;
        req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDE22_BE44);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_accept", {31'd0, req_ready}, 32'd0);
        wait_rsp(lat);
        check("bp_st_lat", lat, 32'd2);
        check("bp_st_rdata", rsp_rdata, 32'd0);
        take_rsp();
        xact(1'b0, 10'h007, 32'd0, 4'h0, d, e, lat);
        check("bp_ld_rdata", d, 32'hCAFE_F00D);

        // Out-of-range store: error flag or wrap into word 0.
        xact(1'b1, 10'h000, 32'h0000_0A5A, 4'hF, d, e, lat);
        xact(1'b1, 10'h200, 32'h1234_5678, 4'hF, d, e, lat);
        check("oor_rdata", d, 32'd0);
`ifdef DMEM_ERR_CHECK_EN
        check("oor_err", {31'd0, e}, 32'd1);
        xact(1'b0, 10'h000, 32'd0, 4'h0, d, e, lat);
        check("oor_mem0", d, 32'h0000_0A5A);
`else
        check("oor_err", {31'd0, e}, 32'd0);
        xact(1'b0, 10'h000, 32'd0, 4'h0, d, e, lat);
        check("oor_mem0", d, 32'h1234_5678);
`endif

        // Reset during wait states discards the store.
        xact(1'b1, 10'h010, 32'h0BAD_F00D, 4'hF, d, e, lat);
        send_req(1'b1, 10'h010, 32'h5555_5555, 4'hF);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        xact(1'b0, 10'h010, 32'd0, 4'h0, d, e, lat);
        check("mid_rst_rdata", d, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
